// File: rtl/sample_scheduler.sv
// Multi-channel periodic sample scheduler: per-channel period counters feed a round-robin
// arbiter that serialises jobs on one shared readout resource. Optional BUSY watchdog: SAMPLE_SCHED_TIMEOUT_EN.
module sample_scheduler #(
    parameter int NUM_CH         = 4,
    parameter int WIDTH          = 21,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [NUM_CH*WIDTH-1:0]     period_in,
    input  logic [NUM_CH-1:0]           enable_in,
    input  logic                        done_in,
    output logic                        start_out,
    output logic [$clog2(NUM_CH)-1:0]   ch_out,
    output logic                        busy_out,
    output logic [NUM_CH-1:0]           pending_out,
    output logic [NUM_CH-1:0]           overrun_out,
    input  logic                        clear_flags_in,
    output logic                        timeout_out
);

    localparam int CW = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    if ((NUM_CH < 2) || (NUM_CH > 8) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("sample_scheduler: parameter out of range");
    end

    state_t                 r_state;
    logic                   r_start;
    logic                   r_busy;
    logic [CW-1:0]          r_ch;
    logic [CW-1:0]          r_rr;
    logic [WIDTH-1:0]       r_count [NUM_CH];
    logic [NUM_CH-1:0]      r_pending;
    logic [NUM_CH-1:0]      r_overrun;

    logic [NUM_CH-1:0]      w_active;
    logic [NUM_CH-1:0]      w_expire;
    logic [NUM_CH-1:0]      w_pending_next;
    logic [NUM_CH-1:0]      w_overrun_next;
    logic [CW:0]            w_pick;
    logic                   w_grant_valid;
    logic [CW-1:0]          w_grant_idx;
    logic                   w_fire;
    logic                   w_to_hit;

    // Round-robin pick: first requester above ptr (wrapping). Returns {valid, index}.
    function automatic logic [CW:0] f_rr_pick(input logic [NUM_CH-1:0] req, input logic [CW-1:0] ptr);
        logic [CW:0] res;
        int          idx;
        res = '0;
        // Walk offsets from farthest to nearest so the nearest requester is the last assignment.
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = (int'(ptr) + i) % NUM_CH;
            if (req[idx]) begin
                res = {1'b1, idx[CW-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign w_pick        = f_rr_pick(r_pending, r_rr);
    assign w_grant_valid = w_pick[CW];
    assign w_grant_idx   = w_pick[CW-1:0];
    assign w_fire        = (r_state == ST_IDLE) && w_grant_valid;

    // Per-channel activity and expiry detection (compare in WIDTH+1 bits so count+1 cannot wrap).
    always_comb begin
        w_active = '0;
        w_expire = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_active[k] = enable_in[k] && (period_in[k*WIDTH +: WIDTH] != {WIDTH{1'b0}});
            w_expire[k] = w_active[k] &&
                (({1'b0, r_count[k]} + {{WIDTH{1'b0}}, 1'b1}) >= {1'b0, period_in[k*WIDTH +: WIDTH]});
        end
    end

    // Next pending/overrun bits; an overrun set wins over a same-cycle clear.
    always_comb begin
        w_pending_next = '0;
        w_overrun_next = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_active[k]) begin
                w_pending_next[k] = 1'b0;
            end else if (w_expire[k]) begin
                w_pending_next[k] = 1'b1;
            end else if (w_fire && (w_grant_idx == CW'(k))) begin
                w_pending_next[k] = 1'b0;
            end else begin
                w_pending_next[k] = r_pending[k];
            end
            w_overrun_next[k] = (clear_flags_in ? 1'b0 : r_overrun[k]) |
                (w_expire[k] && r_pending[k] && !(w_fire && (w_grant_idx == CW'(k))));
        end
    end

    // Period counters: held at zero while inactive, restart from zero on expiry.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_count[k] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!w_active[k] || w_expire[k]) begin
                    r_count[k] <= {WIDTH{1'b0}};
                end else begin
                    r_count[k] <= r_count[k] + {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Request and sticky overrun flag registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_pending <= w_pending_next;
            r_overrun <= w_overrun_next;
        end
    end

    // Job sequencer: grant in IDLE, one-cycle start in ISSUE, wait for done in BUSY.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_ch    <= '0;
            r_rr    <= CW'(NUM_CH - 1);
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_state <= ST_ISSUE;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_ch    <= w_grant_idx;
                        r_rr    <= w_grant_idx;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (done_in) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_BUSY;
                        r_busy  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (done_in || w_to_hit) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_BUSY;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SAMPLE_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tcnt;
    logic          r_timeout;

    // The r_tcnt value in a BUSY cycle is the number of earlier BUSY cycles of this job.
    assign w_to_hit = (r_state == ST_BUSY) && !done_in && (r_tcnt >= TW'(TIMEOUT_CYCLES - 1));

    // Watchdog counter (cleared in ISSUE) and sticky timeout flag; set wins over clear.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_tcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == ST_ISSUE) begin
                r_tcnt <= '0;
            end else if (r_state == ST_BUSY) begin
                r_tcnt <= r_tcnt + {{(TW-1){1'b0}}, 1'b1};
            end else begin
                r_tcnt <= r_tcnt;
            end
            if (w_to_hit) begin
                r_timeout <= 1'b1;
            end else if (clear_flags_in) begin
                r_timeout <= 1'b0;
            end else begin
                r_timeout <= r_timeout;
            end
        end
    end

    assign timeout_out = r_timeout;
`else
    assign w_to_hit    = 1'b0;
    assign timeout_out = 1'b0;
`endif

    assign start_out   = r_start;
    assign ch_out      = r_ch;
    assign busy_out    = r_busy;
    assign pending_out = r_pending;
    assign overrun_out = r_overrun;

endmodule

// File: tb/tb_sample_scheduler.sv
// Self-checking bench for sample_scheduler: randomized and directed stimulus against a
// cycle-level behavioural model of the scheduling rules.
module tb_sample_scheduler;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 21;
    localparam int TO     = 20;
    localparam int CW     = $clog2(NUM_CH);
    localparam int VW     = 3 + CW + 2*NUM_CH;

    logic                    clk_in = 1'b0;
    logic                    rst_in;
    logic [NUM_CH*WIDTH-1:0] period_in;
    logic [NUM_CH-1:0]       enable_in;
    logic                    done_in;
    logic                    start_out;
    logic [CW-1:0]           ch_out;
    logic                    busy_out;
    logic [NUM_CH-1:0]       pending_out;
    logic [NUM_CH-1:0]       overrun_out;
    logic                    clear_flags_in;
    logic                    timeout_out;

    sample_scheduler #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .period_in(period_in), .enable_in(enable_in),
        .done_in(done_in), .start_out(start_out), .ch_out(ch_out), .busy_out(busy_out),
        .pending_out(pending_out), .overrun_out(overrun_out),
        .clear_flags_in(clear_flags_in), .timeout_out(timeout_out)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model state
    int m_cnt  [NUM_CH];
    bit m_pend [NUM_CH];
    bit m_ovr  [NUM_CH];
    bit m_busy, m_start, m_to;
    int m_ch, m_last, m_bcnt;

    // done_in generator
    bit auto_done = 1'b0;
    bit rnd_idle  = 1'b0;
    int done_lo = 0, done_hi = 0;
    bit dwait = 1'b0;
    int dleft = 0;

    function automatic int per_of(input int k);
        logic [WIDTH-1:0] p;
        p = period_in[k*WIDTH +: WIDTH];
        return int'(p);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_cnt[k] = 0; m_pend[k] = 1'b0; m_ovr[k] = 1'b0;
        end
        m_busy = 1'b0; m_start = 1'b0; m_to = 1'b0;
        m_ch = 0; m_last = NUM_CH - 1; m_bcnt = 0;
        dwait = 1'b0;
    endtask

    task automatic model_step();
        bit gv, act, ex, granted, was_issue, to_set;
        int g, p, c;
        bit oset [NUM_CH];
        gv = 1'b0; g = 0; to_set = 1'b0;
        if (!m_busy) begin
            for (int i = 1; i <= NUM_CH; i++) begin
                c = (m_last + i) % NUM_CH;
                if (!gv && m_pend[c]) begin gv = 1'b1; g = c; end
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            p = per_of(k);
            act = enable_in[k] && (p != 0);
            ex = act && (m_cnt[k] + 1 >= p);
            granted = gv && (g == k);
            oset[k] = 1'b0;
            if (!act) begin
                m_cnt[k] = 0; m_pend[k] = 1'b0;
            end else begin
                m_cnt[k] = ex ? 0 : m_cnt[k] + 1;
                if (ex) begin
                    oset[k] = m_pend[k] && !granted;
                    m_pend[k] = 1'b1;
                end else if (granted) begin
                    m_pend[k] = 1'b0;
                end
            end
            m_ovr[k] = (clear_flags_in ? 1'b0 : m_ovr[k]) | oset[k];
        end
        if (!m_busy) begin
            m_start = 1'b0;
            if (gv) begin
                m_busy = 1'b1; m_start = 1'b1; m_ch = g; m_last = g; m_bcnt = 0;
            end
        end else begin
            was_issue = m_start;
            m_start = 1'b0;
            if (done_in) begin
                m_busy = 1'b0;
            end else if (!was_issue) begin
`ifdef SAMPLE_SCHED_TIMEOUT_EN
                m_bcnt++;
                if (m_bcnt >= TO) begin m_busy = 1'b0; to_set = 1'b1; end
`endif
            end
        end
        m_to = (clear_flags_in ? 1'b0 : m_to) | to_set;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [NUM_CH-1:0] pv, ov;
        logic [CW-1:0] cv;
        for (int k = 0; k < NUM_CH; k++) begin pv[k] = m_pend[k]; ov[k] = m_ovr[k]; end
        cv = m_ch[CW-1:0];
        return {m_start, cv, m_busy, pv, ov, m_to};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {start_out, ch_out, busy_out, pending_out, overrun_out, timeout_out};
    endfunction

    // One clock: model follows the DUT edge, done_in is then chosen for the current cycle.
    task automatic tick();
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
        done_in = 1'b0;
        if (auto_done) begin
            if (m_start) begin dwait = 1'b1; dleft = $urandom_range(done_hi, done_lo); end
            if (dwait) begin
                if (dleft == 0) begin done_in = 1'b1; dwait = 1'b0; end
                else dleft--;
            end else if (rnd_idle && !m_busy && ($urandom_range(7, 0) == 0)) begin
                done_in = 1'b1;
            end
        end
    endtask

    task automatic set_period(input int k, input int p);
        period_in[k*WIDTH +: WIDTH] = WIDTH'(p);
    endtask

    task automatic quiesce();
        enable_in = '0; clear_flags_in = 1'b0; rnd_idle = 1'b0;
        auto_done = 1'b1; done_lo = 0; done_hi = 0;
        for (int i = 0; i < 40 && (m_busy || dwait); i++) tick();
        tick();
    endtask

    task automatic test_reset();
        rst_in = 1'b0; enable_in = '0; period_in = '0; done_in = 1'b0; clear_flags_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_in);
        n_vec++;
        if (dut_vec() !== {VW{1'b0}}) begin
            n_err++; $display("FAIL reset_state: got %h want %h", dut_vec(), {VW{1'b0}});
        end
        rst_in = 1'b1;
        tick();
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL reset_idle: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_single_channel();
        quiesce();
        set_period(0, 10); enable_in = 4'b0001; done_lo = 2; done_hi = 2;
        for (int i = 0; i < 60; i++) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL single_ch cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_round_robin();
        quiesce();
        for (int k = 0; k < NUM_CH; k++) set_period(k, 8);
        enable_in = 4'b1111; done_lo = 1; done_hi = 1;
        for (int i = 0; i < 64; i++) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL round_robin cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_overrun();
        quiesce();
        set_period(1, 4); enable_in = 4'b0010; auto_done = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL overrun cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        n_vec++;
        if (overrun_out[1] !== 1'b1 || pending_out[1] !== 1'b1) begin
            n_err++; $display("FAIL overrun_set: got ovr=%b pend=%b want ovr[1]=1 pend[1]=1", overrun_out, pending_out);
        end
        enable_in = '0; clear_flags_in = 1'b1;
        tick();
        clear_flags_in = 1'b0;
        n_vec++;
        if (overrun_out !== 4'b0000 || dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL overrun_clear: got %h want %h", dut_vec(), exp_vec());
        end
        done_in = 1'b1;
        tick();
        n_vec++;
        if (busy_out !== 1'b0 || dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL overrun_release: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_period_change();
        quiesce();
        set_period(2, 100); enable_in = 4'b0100; done_lo = 1; done_hi = 1;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL period_hold cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        set_period(2, 5);
        tick();
        n_vec++;
        if (pending_out[2] !== 1'b1) begin
            n_err++; $display("FAIL period_lower: got pending=%b want pending[2]=1", pending_out);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL period_new cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        quiesce();
        for (int k = 0; k < NUM_CH; k++) set_period(k, $urandom_range(12, 1));
        enable_in = 4'b1111; rnd_idle = 1'b1; done_lo = 0; done_hi = 4;
        for (int i = 0; i < 500; i++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if ($urandom_range(15, 0) == 0) set_period(k, $urandom_range(12, 0));
                if ($urandom_range(19, 0) == 0) enable_in[k] = ~enable_in[k];
            end
            clear_flags_in = ($urandom_range(15, 0) == 0);
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL random cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        clear_flags_in = 1'b0; rnd_idle = 1'b0;
    endtask

    task automatic test_async_reset();
        quiesce();
        for (int k = 0; k < NUM_CH; k++) set_period(k, 3);
        enable_in = 4'b1110; auto_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL pre_reset cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        #2 rst_in = 1'b0;
        #1;
        n_vec++;
        if (dut_vec() !== {VW{1'b0}}) begin
            n_err++; $display("FAIL async_reset: got %h want %h", dut_vec(), {VW{1'b0}});
        end
        model_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        enable_in = 4'b1111; auto_done = 1'b1; done_lo = 1; done_hi = 1;
        rst_in = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL post_reset cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

`ifdef SAMPLE_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        quiesce();
        set_period(0, 40); set_period(1, 40); enable_in = 4'b0011; auto_done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL timeout cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        n_vec++;
        if (timeout_out !== 1'b1) begin
            n_err++; $display("FAIL timeout_flag: got %b want 1", timeout_out);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_single_channel();
        test_round_robin();
        test_overrun();
        test_period_change();
        test_random();
        test_async_reset();
`ifdef SAMPLE_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
